// File: rtl/bus_err_unit_tracked.sv
// Multi-channel bus error logger: per-channel request trackers matched against
// response bursts, with a pop-style error FIFO, saturating counter and fill IRQ.
module bus_err_unit_tracked #(
  parameter int unsigned AddrWidth       = 48,
  parameter int unsigned MetaDataWidth   = 1,
  parameter int unsigned ErrBits         = 3,
  parameter int unsigned NumChannels     = 2,
  parameter int unsigned NumOutstanding  = 4,
  parameter int unsigned NumStoredErrors = 4,
  parameter bit          DropOldest      = 1'b0,
  parameter int unsigned CntWidth        = 16,
  parameter int unsigned ChanW           = (NumChannels > 1) ? $clog2(NumChannels) : 1
) (
  input  logic                               clk_i,
  input  logic                               rst_ni,
  input  logic [NumChannels-1:0]             req_hs_valid_i,
  input  logic [AddrWidth-1:0]               req_addr_i,
  input  logic [MetaDataWidth-1:0]           req_meta_i,
  input  logic [NumChannels-1:0]             rsp_hs_valid_i,
  input  logic [NumChannels-1:0]             rsp_burst_last_i,
  input  logic [ErrBits-1:0]                 rsp_err_i,
  input  logic [ErrBits-1:0]                 err_mask_i,
  input  logic [$clog2(NumStoredErrors+1)-1:0] irq_thresh_i,
  input  logic                               err_cnt_clr_i,
  input  logic                               err_pop_i,
  output logic                               err_valid_o,
  output logic [AddrWidth-1:0]               err_addr_o,
  output logic [MetaDataWidth-1:0]           err_meta_o,
  output logic [ErrBits-1:0]                 err_code_o,
  output logic [ChanW-1:0]                   err_chan_o,
  output logic                               err_overflow_o,
  output logic [CntWidth-1:0]                err_cnt_o,
  output logic                               err_irq_o,
  output logic                               track_ovf_o,
  output logic                               track_unf_o
);

  localparam int unsigned FillW   = $clog2(NumStoredErrors + 1);
  localparam int unsigned FPtrW   = (NumStoredErrors > 1) ? $clog2(NumStoredErrors) : 1;
  localparam int unsigned TPtrW   = (NumOutstanding > 1) ? $clog2(NumOutstanding) : 1;
  localparam int unsigned TCntW   = $clog2(NumOutstanding + 1);

  typedef struct packed {
    logic [AddrWidth-1:0]     addr;
    logic [MetaDataWidth-1:0] meta;
  } trk_entry_t;

  typedef struct packed {
    logic [AddrWidth-1:0]     addr;
    logic [MetaDataWidth-1:0] meta;
    logic [ErrBits-1:0]       code;
    logic [ChanW-1:0]         chan;
  } err_entry_t;

  function automatic logic [TPtrW-1:0] trk_inc(input logic [TPtrW-1:0] p);
    return (p == TPtrW'(NumOutstanding - 1)) ? '0 : p + TPtrW'(1);
  endfunction

  function automatic logic [FPtrW-1:0] fifo_inc(input logic [FPtrW-1:0] p);
    return (p == FPtrW'(NumStoredErrors - 1)) ? '0 : p + FPtrW'(1);
  endfunction

  // Handshakes: a request or response beat transfers in any cycle its one-hot
  // valid bit is high; the block never back-pressures, it drops and flags instead.
  // err_pop_i removes the FIFO head in a cycle where err_valid_o is high.

  trk_entry_t                trk_mem [NumChannels][NumOutstanding];
  logic [TPtrW-1:0]          trk_wr  [NumChannels];
  logic [TPtrW-1:0]          trk_rd  [NumChannels];
  logic [TCntW-1:0]          trk_cnt [NumChannels];
  logic [NumChannels-1:0]    burst_err_q;

  err_entry_t                err_mem [NumStoredErrors];
  logic [FPtrW-1:0]          err_wr, err_rd;
  logic [FillW-1:0]          fill_q;
  logic                      ovf_q;
  logic [CntWidth-1:0]       cnt_q;
  logic                      track_ovf_q, track_unf_q;

  logic [NumChannels-1:0]    trk_empty, trk_full, rsp_hit, trk_pop, trk_push;
  logic [ChanW-1:0]          rsp_chan;
  trk_entry_t                req_entry, rsp_head;
  err_entry_t                cap_entry;
  logic                      err_beat, capture, req_drop, rsp_unf;
  logic                      pop_acc, fifo_full, drop, wr_en, rd_adv;

  assign req_entry = '{addr: req_addr_i, meta: req_meta_i};

  always_comb begin
    rsp_chan = '0;
    for (int c = 0; c < NumChannels; c++) begin
      trk_empty[c] = (trk_cnt[c] == '0);
      trk_full[c]  = (trk_cnt[c] == TCntW'(NumOutstanding));
      // A beat on an empty tracker still matches a request pushed the same cycle.
      rsp_hit[c]   = rsp_hs_valid_i[c] & (~trk_empty[c] | req_hs_valid_i[c]);
      trk_pop[c]   = rsp_hit[c] & rsp_burst_last_i[c];
      trk_push[c]  = req_hs_valid_i[c] & (~trk_full[c] | trk_pop[c]);
      if (rsp_hs_valid_i[c]) rsp_chan = ChanW'(c);
    end
  end

  assign req_drop = |(req_hs_valid_i & trk_full & ~trk_pop);
  assign rsp_unf  = |(rsp_hs_valid_i & trk_empty & ~req_hs_valid_i);
  assign err_beat = (|rsp_hs_valid_i) & (|(rsp_err_i & ~err_mask_i));
  assign rsp_head = trk_empty[rsp_chan] ? req_entry : trk_mem[rsp_chan][trk_rd[rsp_chan]];
  assign capture  = err_beat & rsp_hit[rsp_chan] & ~burst_err_q[rsp_chan];
  assign cap_entry = '{addr: rsp_head.addr, meta: rsp_head.meta, code: rsp_err_i, chan: rsp_chan};

  assign pop_acc   = err_pop_i & (fill_q != '0);
  assign fifo_full = (fill_q == FillW'(NumStoredErrors));
  assign drop      = capture & fifo_full & ~pop_acc;
  assign wr_en     = capture & (~fifo_full | pop_acc | DropOldest);
  assign rd_adv    = pop_acc | (drop & DropOldest);

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int c = 0; c < NumChannels; c++) begin
        trk_wr[c]  <= '0;
        trk_rd[c]  <= '0;
        trk_cnt[c] <= '0;
      end
      burst_err_q <= '0;
      err_wr      <= '0;
      err_rd      <= '0;
      fill_q      <= '0;
      ovf_q       <= 1'b0;
      cnt_q       <= '0;
      track_ovf_q <= 1'b0;
      track_unf_q <= 1'b0;
    end else begin
      for (int c = 0; c < NumChannels; c++) begin
        if (trk_push[c]) trk_wr[c] <= trk_inc(trk_wr[c]);
        if (trk_pop[c])  trk_rd[c] <= trk_inc(trk_rd[c]);
        if (trk_push[c] && !trk_pop[c])      trk_cnt[c] <= trk_cnt[c] + TCntW'(1);
        else if (!trk_push[c] && trk_pop[c]) trk_cnt[c] <= trk_cnt[c] - TCntW'(1);
        if (rsp_hs_valid_i[c] && rsp_burst_last_i[c]) burst_err_q[c] <= 1'b0;
        else if (capture && (rsp_chan == ChanW'(c))) burst_err_q[c] <= 1'b1;
      end
      if (wr_en)  err_wr <= fifo_inc(err_wr);
      if (rd_adv) err_rd <= fifo_inc(err_rd);
      if (wr_en && !rd_adv)      fill_q <= fill_q + FillW'(1);
      else if (!wr_en && rd_adv) fill_q <= fill_q - FillW'(1);
      if (drop)         ovf_q <= 1'b1;
      else if (pop_acc) ovf_q <= 1'b0;
      if (err_cnt_clr_i)      cnt_q <= capture ? CntWidth'(1) : '0;
      else if (capture && !(&cnt_q)) cnt_q <= cnt_q + CntWidth'(1);
      track_ovf_q <= req_drop;
      track_unf_q <= rsp_unf;
    end
  end

  // Storage arrays carry no reset; occupancy counters alone define validity.
  always_ff @(posedge clk_i) begin
    for (int c = 0; c < NumChannels; c++) begin
      if (trk_push[c]) trk_mem[c][trk_wr[c]] <= req_entry;
    end
    if (wr_en) err_mem[err_wr] <= cap_entry;
  end

  assign err_valid_o    = (fill_q != '0);
  assign err_addr_o     = err_valid_o ? err_mem[err_rd].addr : '0;
  assign err_meta_o     = err_valid_o ? err_mem[err_rd].meta : '0;
  assign err_code_o     = err_valid_o ? err_mem[err_rd].code : '0;
  assign err_chan_o     = err_valid_o ? err_mem[err_rd].chan : '0;
  assign err_overflow_o = ovf_q;
  assign err_cnt_o      = cnt_q;
  assign err_irq_o      = (irq_thresh_i != '0) && (fill_q >= irq_thresh_i);
  assign track_ovf_o    = track_ovf_q;
  assign track_unf_o    = track_unf_q;

endmodule

// File: tb/tb_bus_err_unit_tracked.sv
// Directed bench for bus_err_unit_tracked: two instances (drop-new and drop-oldest)
// share stimulus; a monitor checks popped FIFO heads against expected queues.
module tb_bus_err_unit_tracked;
  localparam int EW = 48 + 1 + 3 + 1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  req_hs_valid = '0;
  logic [47:0] req_addr = '0;
  logic        req_meta = 1'b0;
  logic [1:0]  rsp_hs_valid = '0;
  logic [1:0]  rsp_burst_last = '0;
  logic [2:0]  rsp_err = '0;
  logic [2:0]  err_mask = '0;
  logic [2:0]  irq_thresh = '0;
  logic        err_cnt_clr = 1'b0;
  logic        err_pop = 1'b0;

  logic        v0, meta0, chan0, ovf0, irq0, tovf0, tunf0;
  logic [47:0] addr0;
  logic [2:0]  code0;
  logic [15:0] cnt0;
  logic        v1, meta1, chan1, ovf1, irq1, tovf1, tunf1;
  logic [47:0] addr1;
  logic [2:0]  code1;
  logic [15:0] cnt1;

  logic [EW-1:0] exp_q0[$];
  logic [EW-1:0] exp_q1[$];
  int total = 0;
  int bad = 0;

  bus_err_unit_tracked #(.DropOldest(1'b0)) dut0 (
    .clk_i(clk), .rst_ni(rst_n), .req_hs_valid_i(req_hs_valid), .req_addr_i(req_addr),
    .req_meta_i(req_meta), .rsp_hs_valid_i(rsp_hs_valid), .rsp_burst_last_i(rsp_burst_last),
    .rsp_err_i(rsp_err), .err_mask_i(err_mask), .irq_thresh_i(irq_thresh),
    .err_cnt_clr_i(err_cnt_clr), .err_pop_i(err_pop), .err_valid_o(v0), .err_addr_o(addr0),
    .err_meta_o(meta0), .err_code_o(code0), .err_chan_o(chan0), .err_overflow_o(ovf0),
    .err_cnt_o(cnt0), .err_irq_o(irq0), .track_ovf_o(tovf0), .track_unf_o(tunf0)
  );

  bus_err_unit_tracked #(.DropOldest(1'b1)) dut1 (
    .clk_i(clk), .rst_ni(rst_n), .req_hs_valid_i(req_hs_valid), .req_addr_i(req_addr),
    .req_meta_i(req_meta), .rsp_hs_valid_i(rsp_hs_valid), .rsp_burst_last_i(rsp_burst_last),
    .rsp_err_i(rsp_err), .err_mask_i(err_mask), .irq_thresh_i(irq_thresh),
    .err_cnt_clr_i(err_cnt_clr), .err_pop_i(err_pop), .err_valid_o(v1), .err_addr_o(addr1),
    .err_meta_o(meta1), .err_code_o(code1), .err_chan_o(chan1), .err_overflow_o(ovf1),
    .err_cnt_o(cnt1), .err_irq_o(irq1), .track_ovf_o(tovf1), .track_unf_o(tunf1)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // expected FIFO contents: dut0 drops the new entry when full, dut1 drops the oldest
  function automatic void push_exp(input logic [EW-1:0] e);
    logic [EW-1:0] tmp;
    if (exp_q0.size() < 4) exp_q0.push_back(e);
    if (exp_q1.size() >= 4) tmp = exp_q1.pop_front();
    exp_q1.push_back(e);
  endfunction

  // driver tasks
  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic step(input logic [1:0] rq, input logic [47:0] ra, input logic rm,
                      input logic [1:0] rs, input logic [1:0] rl, input logic [2:0] re,
                      input bit cap, input logic [47:0] ea, input logic em);
    req_hs_valid = rq; req_addr = ra; req_meta = rm;
    rsp_hs_valid = rs; rsp_burst_last = rl; rsp_err = re;
    cyc();
    if (cap) push_exp({ea, em, re, rs[1]});
    req_hs_valid = '0; rsp_hs_valid = '0; rsp_burst_last = '0; rsp_err = '0;
  endtask

  task automatic req(input int ch, input logic [47:0] a, input logic m);
    step(ch ? 2'b10 : 2'b01, a, m, 2'b00, 2'b00, 3'd0, 1'b0, '0, 1'b0);
  endtask

  task automatic rsp(input int ch, input logic last, input logic [2:0] e,
                     input bit cap, input logic [47:0] ea, input logic em);
    logic [1:0] oh;
    oh = ch ? 2'b10 : 2'b01;
    step(2'b00, '0, 1'b0, oh, last ? oh : 2'b00, e, cap, ea, em);
  endtask

  task automatic pop();
    err_pop = 1'b1; cyc(); err_pop = 1'b0;
  endtask

  task automatic clr_cnt();
    err_cnt_clr = 1'b1; cyc(); err_cnt_clr = 1'b0;
  endtask

  // scoreboard monitor: valid must track queue occupancy; popped heads must match
  always @(negedge clk) begin
    logic [EW-1:0] e;
    if (rst_n) begin
      check("valid0", v0, exp_q0.size() != 0);
      check("valid1", v1, exp_q1.size() != 0);
      if (err_pop && v0 && exp_q0.size() != 0) begin
        e = exp_q0.pop_front();
        check("head0", {addr0, meta0, code0, chan0}, e);
      end
      if (err_pop && v1 && exp_q1.size() != 0) begin
        e = exp_q1.pop_front();
        check("head1", {addr1, meta1, code1, chan1}, e);
      end
    end
  end

  initial begin
    cyc(); cyc();
    // reset state
    check("rst_valid", v0, 0);
    check("rst_addr", addr0, 0);
    check("rst_cnt", cnt0, 0);
    check("rst_ovf", ovf0, 0);
    check("rst_irq", irq0, 0);
    check("rst_tovf", tovf0, 0);
    check("rst_tunf", tunf0, 0);
    rst_n = 1'b1;
    cyc();

    // single-beat error burst
    req(0, 48'h1000, 1'b1);
    rsp(0, 1'b1, 3'd2, 1'b1, 48'h1000, 1'b1);
    check("t1_cnt", cnt0, 1);
    check("t1_code", code0, 2);
    pop();
    check("t1_empty", v0, 0);

    // multi-beat burst: only first error beat captured
    clr_cnt();
    req(1, 48'hA0, 1'b0);
    req(1, 48'hB0, 1'b0);
    rsp(1, 1'b0, 3'd0, 1'b0, '0, 1'b0);
    rsp(1, 1'b0, 3'd1, 1'b1, 48'hA0, 1'b0);
    rsp(1, 1'b0, 3'd4, 1'b0, '0, 1'b0);
    rsp(1, 1'b1, 3'd0, 1'b0, '0, 1'b0);
    rsp(1, 1'b0, 3'd0, 1'b0, '0, 1'b0);
    rsp(1, 1'b1, 3'd0, 1'b0, '0, 1'b0);
    check("t2_cnt", cnt0, 1);
    check("t2_chan", chan0, 1);
    rsp(1, 1'b1, 3'd0, 1'b0, '0, 1'b0);
    check("t2_trk_empty", tunf0, 1);
    pop();

    // error mask
    clr_cnt();
    err_mask = 3'b001;
    req(0, 48'h400, 1'b0);
    rsp(0, 1'b1, 3'd1, 1'b0, '0, 1'b0);
    check("t3_masked_cnt", cnt0, 0);
    req(0, 48'h410, 1'b0);
    rsp(0, 1'b1, 3'd5, 1'b1, 48'h410, 1'b0);
    check("t3_cnt", cnt0, 1);
    check("t3_code", code0, 5);
    pop();
    err_mask = 3'b000;

    // FIFO overflow, both drop policies
    clr_cnt();
    for (int i = 1; i <= 5; i++) begin
      req(0, 48'(i * 16), 1'b0);
      rsp(0, 1'b1, 3'd3, 1'b1, 48'(i * 16), 1'b0);
    end
    check("t4_ovf0", ovf0, 1);
    check("t4_ovf1", ovf1, 1);
    check("t4_cnt", cnt0, 5);
    check("t4_head0", addr0, 48'h10);
    check("t4_head1", addr1, 48'h20);
    pop();
    check("t4_ovf0_clr", ovf0, 0);
    check("t4_ovf1_clr", ovf1, 0);
    for (int i = 0; i < 3; i++) pop();

    // tracker overflow, full tracker with same-cycle pop
    clr_cnt();
    for (int i = 0; i < 4; i++) req(0, 48'h100 + 48'(i * 16), 1'b0);
    check("t5_no_ovf", tovf0, 0);
    req(0, 48'h140, 1'b0);
    check("t5_ovf_pulse", tovf0, 1);
    cyc();
    check("t5_ovf_once", tovf0, 0);
    step(2'b01, 48'h150, 1'b0, 2'b01, 2'b01, 3'd0, 1'b0, '0, 1'b0);
    check("t5_full_pop_accept", tovf0, 0);
    rsp(0, 1'b1, 3'd2, 1'b1, 48'h110, 1'b0);
    rsp(0, 1'b1, 3'd0, 1'b0, '0, 1'b0);
    rsp(0, 1'b1, 3'd0, 1'b0, '0, 1'b0);
    rsp(0, 1'b1, 3'd6, 1'b1, 48'h150, 1'b0);
    rsp(1, 1'b1, 3'd7, 1'b0, '0, 1'b0);
    check("t5_unf_pulse", tunf0, 1);
    check("t5_cnt", cnt0, 2);
    pop(); pop();

    // IRQ threshold and counter clear priority
    clr_cnt();
    irq_thresh = 3'd2;
    req(0, 48'h200, 1'b0);
    rsp(0, 1'b1, 3'd1, 1'b1, 48'h200, 1'b0);
    check("t6_irq_lo", irq0, 0);
    req(0, 48'h210, 1'b0);
    rsp(0, 1'b1, 3'd1, 1'b1, 48'h210, 1'b0);
    check("t6_irq_hi", irq0, 1);
    pop();
    check("t6_irq_pop", irq0, 0);
    pop();
    irq_thresh = 3'd0;
    check("t6_cnt_pre", cnt0, 2);
    req(0, 48'h220, 1'b0);
    err_cnt_clr = 1'b1;
    rsp(0, 1'b1, 3'd2, 1'b1, 48'h220, 1'b0);
    err_cnt_clr = 1'b0;
    check("t6_clr_and_err", cnt0, 1);
    pop();

    // reset mid-burst
    irq_thresh = 3'd1;
    req(1, 48'h300, 1'b0);
    rsp(1, 1'b0, 3'd3, 1'b1, 48'h300, 1'b0);
    check("t7_irq_pre", irq0, 1);
    rst_n = 1'b0;
    cyc();
    exp_q0.delete();
    exp_q1.delete();
    check("t7_valid", v0, 0);
    check("t7_addr", addr0, 0);
    check("t7_cnt", cnt0, 0);
    check("t7_irq", irq0, 0);
    check("t7_ovf", ovf0, 0);
    rst_n = 1'b1;
    irq_thresh = 3'd0;
    cyc();
    rsp(1, 1'b1, 3'd3, 1'b0, '0, 1'b0);
    check("t7_trk_cleared", tunf0, 1);
    req(1, 48'h310, 1'b0);
    rsp(1, 1'b1, 3'd4, 1'b1, 48'h310, 1'b0);
    check("t7_cnt_after", cnt0, 1);
    pop();
    cyc(); cyc();
    check("q0_drained", exp_q0.size(), 0);
    check("q1_drained", exp_q1.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/bus_err_unit_tracked.md
Name: bus_err_unit_tracked

Overview:
Multi-channel bus error logger. Tracks outstanding request addresses and metadata per channel, and matches each response burst to its oldest outstanding request. Bursts carrying unmasked error codes are recorded into a readable error FIFO. Sits beside a manager port. It is register-interface-agnostic, with a pop-style read side, a running error counter and a threshold interrupt.

Parameters:
AddrWidth, 48, request address width
MetaDataWidth, 1, request metadata width
ErrBits, 3, response error code width
NumChannels, 2, channels; request/response valids are one-hot across channels
NumOutstanding, 4, tracker depth per channel (>=1)
NumStoredErrors, 4, error FIFO depth (>=1)
DropOldest, 0, 1: full FIFO drops head to keep new error; 0: drops new error
CntWidth, 16, error counter width
ChanW, max(1,$clog2(NumChannels)), derived, channel index width

Ports:
clk_i  in  1  clock
rst_ni  in  1  synchronous active-low reset, sampled on rising edge of clk_i
req_hs_valid_i  in  NumChannels  one-hot request handshake
req_addr_i  in  AddrWidth  request address
req_meta_i  in  MetaDataWidth  request metadata
rsp_hs_valid_i  in  NumChannels  one-hot response beat handshake
rsp_burst_last_i  in  NumChannels  last beat of burst, per channel
rsp_err_i  in  ErrBits  response error code (0 = OK)
err_mask_i  in  ErrBits  set bits ignored in error detection
irq_thresh_i  in  $clog2(NumStoredErrors+1)  IRQ fill threshold; 0 disables IRQ
err_cnt_clr_i  in  1  clears error counter
err_pop_i  in  1  pop FIFO head
err_valid_o  out  1  FIFO non-empty
err_addr_o  out  AddrWidth  head address
err_meta_o  out  MetaDataWidth  head metadata
err_code_o  out  ErrBits  head error code (unmasked raw code)
err_chan_o  out  ChanW  head channel index
err_overflow_o  out  1  sticky: an error was dropped
err_cnt_o  out  CntWidth  detected-error count, saturating
err_irq_o  out  1  fill level >= irq_thresh_i and irq_thresh_i != 0
track_ovf_o  out  1  one-cycle pulse: request dropped, tracker full
track_unf_o  out  1  one-cycle pulse: response arrived with tracker empty

Behaviour:
- Reset: all trackers and FIFO empty; burst-error flags, overflow, counter and pulses at 0. Every output is therefore 0 after reset.
- Request on channel c pushes {addr, meta} into tracker c.
- If tracker c is full and there is no same-cycle pop on c, the request is dropped and track_ovf_o pulses next cycle.
- A full tracker with a same-cycle pop accepts the request.
- An error beat is a response beat where (rsp_err_i & ~err_mask_i) != 0.
- The first error beat of a burst on channel c captures {tracker c head, raw rsp_err_i, c}. Capture uses the head before any same-cycle push.
- A per-channel flag suppresses further captures until the burst's last beat. The last beat pops the tracker head and clears the flag.
- A response beat with tracker c empty (and no same-cycle push) is not captured and does not count; track_unf_o pulses.
- A same-cycle request on an empty tracker is still pushed.
- Latency: an error beat in cycle t gives err_valid_o and err_cnt_o updated in cycle t+1. err_irq_o is combinational from the fill level.
- FIFO push when full without a same-cycle pop:
  - DropOldest=1: head is discarded and the new entry is appended.
  - DropOldest=0: the new entry is discarded.
  - Either mode sets err_overflow_o.
- FIFO push with a same-cycle pop while full: both happen, no overflow.
- Pop while empty: ignored.
- err_overflow_o clears on an accepted pop, unless a drop occurs in the same cycle.
- err_cnt_o increments on every captured error, including dropped ones, and saturates at all-ones.
- err_cnt_clr_i has priority over increment. A same-cycle clear and error gives err_cnt_o = 1.
- Head outputs are undefined-but-stable when err_valid_o = 0; they are driven 0.
- Reset asserted mid-burst discards all tracker and FIFO state in one cycle.

Test Plan:
- Ch0 req 0x1000, then ch0 single-beat rsp with err=2 -> next cycle err_valid_o=1, addr=0x1000, code=2, chan=0, cnt=1; pop -> err_valid_o=0.
- Ch1 reqs 0xA0, 0xB0; 4-beat burst with err on beats 1 and 2, last on 3; second burst OK -> one FIFO entry only, addr=0xA0, cnt=1; tracker ch1 empty afterwards.
- err_mask_i=3'b001, rsp_err_i=1 -> no capture, cnt=0. Then rsp_err_i=5 -> captured with code=5.
- DropOldest=0, 5 errors at addrs 0x10..0x50 -> FIFO holds 0x10..0x40, overflow=1, cnt=5; one pop -> overflow=0. Repeat with DropOldest=1 -> FIFO holds 0x20..0x50.
- NumOutstanding=4: 5 ch0 reqs without rsp -> track_ovf_o pulses once. Response with empty ch1 tracker -> track_unf_o pulse, no capture.
- irq_thresh_i=2: one error -> irq=0; second -> irq=1; pop -> irq=0. err_cnt_clr_i with a simultaneous error -> cnt=1. Assert rst_ni mid-burst -> all outputs 0 next cycle.
